// File: rtl/mem_rd_arbiter_if.sv
// Read-channel bundle between the I/D-cache miss paths, the arbiter and memory.
// master = arbiter view, slave = cache/memory-side view.
interface mem_rd_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  from_ic_rd_req_valid;
   logic [ADDR_WIDTH-1:0] from_ic_rd_req_addr;
   logic                  to_ic_rd_req_ready;
   logic                  to_ic_rd_rsp_valid;
   logic [DATA_WIDTH-1:0] to_ic_rd_rsp_data;
   logic                  to_ic_rd_rsp_last;
   logic                  from_ic_rd_rsp_ready;

   logic                  from_dc_rd_req_valid;
   logic [ADDR_WIDTH-1:0] from_dc_rd_req_addr;
   logic                  to_dc_rd_req_ready;
   logic                  to_dc_rd_rsp_valid;
   logic [DATA_WIDTH-1:0] to_dc_rd_rsp_data;
   logic                  to_dc_rd_rsp_last;
   logic                  from_dc_rd_rsp_ready;

   logic                  to_mem_rd_req_valid;
   logic [ADDR_WIDTH-1:0] to_mem_rd_req_addr;
   logic                  from_mem_rd_req_ready;
   logic                  from_mem_rd_rsp_valid;
   logic [DATA_WIDTH-1:0] from_mem_rd_rsp_data;
   logic                  from_mem_rd_rsp_last;
   logic                  to_mem_rd_rsp_ready;

   modport master (
      input  from_ic_rd_req_valid, from_ic_rd_req_addr, from_ic_rd_rsp_ready,
      output to_ic_rd_req_ready, to_ic_rd_rsp_valid, to_ic_rd_rsp_data, to_ic_rd_rsp_last,
      input  from_dc_rd_req_valid, from_dc_rd_req_addr, from_dc_rd_rsp_ready,
      output to_dc_rd_req_ready, to_dc_rd_rsp_valid, to_dc_rd_rsp_data, to_dc_rd_rsp_last,
      output to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_rsp_ready,
      input  from_mem_rd_req_ready, from_mem_rd_rsp_valid, from_mem_rd_rsp_data,
      input  from_mem_rd_rsp_last
   );

   modport slave (
      output from_ic_rd_req_valid, from_ic_rd_req_addr, from_ic_rd_rsp_ready,
      input  to_ic_rd_req_ready, to_ic_rd_rsp_valid, to_ic_rd_rsp_data, to_ic_rd_rsp_last,
      output from_dc_rd_req_valid, from_dc_rd_req_addr, from_dc_rd_rsp_ready,
      input  to_dc_rd_req_ready, to_dc_rd_rsp_valid, to_dc_rd_rsp_data, to_dc_rd_rsp_last,
      input  to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_rsp_ready,
      output from_mem_rd_req_ready, from_mem_rd_rsp_valid, from_mem_rd_rsp_data,
      output from_mem_rd_rsp_last
   );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Two-way (I-cache / D-cache) arbiter for the single memory read channel; grant held for a whole burst.
// MEM_RD_ARB_RR_EN selects round-robin tie-breaking; otherwise the D-cache wins ties.
module mem_rd_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic              clk,
   input logic              rst,
   mem_rd_arbiter_if.master bus
);
   typedef enum logic [2:0] {IDLE = 3'b001, REQ = 3'b010, RSP = 3'b100} state_t;

   state_t                     state, state_nxt;
   logic                       gnt, gnt_nxt, pick;
   // index 0 = I-cache, 1 = D-cache
   logic [1:0]                 req_v, req_rdy, rsp_v, rsp_l, rsp_rdy_in;
   logic [1:0][ADDR_WIDTH-1:0] req_a;
   logic                       mem_req_v, mem_rsp_rdy;
   logic [ADDR_WIDTH-1:0]      mem_addr;
   logic [DATA_WIDTH-1:0]      rsp_d;

   assign req_v      = {bus.from_dc_rd_req_valid, bus.from_ic_rd_req_valid};
   assign req_a      = {bus.from_dc_rd_req_addr, bus.from_ic_rd_req_addr};
   assign rsp_rdy_in = {bus.from_dc_rd_rsp_ready, bus.from_ic_rd_rsp_ready};

`ifdef MEM_RD_ARB_RR_EN
   logic ptr;  // last granted requester; 0 at reset so the first tie goes to the D-cache

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                         ptr <= 1'b0;
      else if (state == IDLE && |req_v) ptr <= pick;
   end

   assign pick = (&req_v) ? ~ptr : req_v[1];
`else
   assign pick = req_v[1];
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         gnt   <= 1'b0;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      gnt_nxt     = gnt;
      req_rdy     = '0;
      rsp_v       = '0;
      rsp_l       = '0;
      rsp_d       = '0;
      mem_req_v   = 1'b0;
      mem_addr    = '0;
      mem_rsp_rdy = 1'b0;
      case (state)
         IDLE: begin
            if (|req_v) begin
               gnt_nxt   = pick;
               state_nxt = REQ;
            end
         end
         REQ: begin
            mem_req_v    = req_v[gnt];
            mem_addr     = req_a[gnt];
            req_rdy[gnt] = bus.from_mem_rd_req_ready;
            // a withdrawn request is dropped without issuing anything
            if (!req_v[gnt])                       state_nxt = IDLE;
            else if (bus.from_mem_rd_req_ready)    state_nxt = RSP;
         end
         RSP: begin
            rsp_v[gnt]  = bus.from_mem_rd_rsp_valid;
            rsp_l[gnt]  = bus.from_mem_rd_rsp_last;
            rsp_d       = bus.from_mem_rd_rsp_data;
            mem_rsp_rdy = rsp_rdy_in[gnt];
            if (bus.from_mem_rd_rsp_valid && rsp_rdy_in[gnt] && bus.from_mem_rd_rsp_last)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.to_ic_rd_req_ready  = req_rdy[0];
   assign bus.to_ic_rd_rsp_valid  = rsp_v[0];
   assign bus.to_ic_rd_rsp_last   = rsp_l[0];
   assign bus.to_ic_rd_rsp_data   = rsp_d;
   assign bus.to_dc_rd_req_ready  = req_rdy[1];
   assign bus.to_dc_rd_rsp_valid  = rsp_v[1];
   assign bus.to_dc_rd_rsp_last   = rsp_l[1];
   assign bus.to_dc_rd_rsp_data   = rsp_d;
   assign bus.to_mem_rd_req_valid = mem_req_v;
   assign bus.to_mem_rd_req_addr  = mem_addr;
   assign bus.to_mem_rd_rsp_ready = mem_rsp_rdy;
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter; tie-break expectations follow MEM_RD_ARB_RR_EN.
module tb_mem_rd_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   mem_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   mem_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.from_ic_rd_req_valid  = 1'b0;
      bus.from_ic_rd_req_addr   = '0;
      bus.from_ic_rd_rsp_ready  = 1'b0;
      bus.from_dc_rd_req_valid  = 1'b0;
      bus.from_dc_rd_req_addr   = '0;
      bus.from_dc_rd_rsp_ready  = 1'b0;
      bus.from_mem_rd_req_ready = 1'b0;
      bus.from_mem_rd_rsp_valid = 1'b0;
      bus.from_mem_rd_rsp_data  = '0;
      bus.from_mem_rd_rsp_last  = 1'b0;
   endtask

   // Entered #1 after the edge that moved the arbiter into REQ; memory request ready is 1.
   task automatic serve(input bit dc, input logic [31:0] addr, input int n, input logic [31:0] dbase);
      chk("req_valid", bus.to_mem_rd_req_valid, 1'b1);
      chk("req_addr", bus.to_mem_rd_req_addr, addr);
      chk("gnt_req_ready", dc ? bus.to_dc_rd_req_ready : bus.to_ic_rd_req_ready, 1'b1);
      chk("oth_req_ready", dc ? bus.to_ic_rd_req_ready : bus.to_dc_rd_req_ready, 1'b0);
      tick();
      if (dc) bus.from_dc_rd_req_valid = 1'b0;
      else    bus.from_ic_rd_req_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus.from_mem_rd_rsp_valid = 1'b1;
         bus.from_mem_rd_rsp_data  = dbase + 32'(i);
         bus.from_mem_rd_rsp_last  = (i == n - 1);
         if (dc) bus.from_dc_rd_rsp_ready = 1'b1;
         else    bus.from_ic_rd_rsp_ready = 1'b1;
         #1;
         chk("beat_valid", dc ? bus.to_dc_rd_rsp_valid : bus.to_ic_rd_rsp_valid, 1'b1);
         chk("beat_data", dc ? bus.to_dc_rd_rsp_data : bus.to_ic_rd_rsp_data, dbase + 32'(i));
         chk("beat_last", dc ? bus.to_dc_rd_rsp_last : bus.to_ic_rd_rsp_last, (i == n - 1));
         chk("oth_rsp_valid", dc ? bus.to_ic_rd_rsp_valid : bus.to_dc_rd_rsp_valid, 1'b0);
         chk("mem_rsp_ready", bus.to_mem_rd_rsp_ready, 1'b1);
         tick();
      end
      bus.from_mem_rd_rsp_valid = 1'b0;
      bus.from_mem_rd_rsp_last  = 1'b0;
      bus.from_ic_rd_rsp_ready  = 1'b0;
      bus.from_dc_rd_rsp_ready  = 1'b0;
      #1;
      chk("idle_after_burst", 3'(dut.state), 3'b001);
      chk("idle_req_valid", bus.to_mem_rd_req_valid, 1'b0);
   endtask

   initial begin
      bit   exp_dc;
      int   beat;
      clear_inputs();

      // reset holds every output low even with a request pending
      bus.from_ic_rd_req_valid = 1'b1;
      bus.from_ic_rd_req_addr  = 32'h0000_0ABC;
      bus.from_mem_rd_req_ready = 1'b1;
      tick(); tick();
      chk("rst_state", 3'(dut.state), 3'b001);
      chk("rst_req_valid", bus.to_mem_rd_req_valid, 1'b0);
      chk("rst_req_addr", bus.to_mem_rd_req_addr, 32'h0);
      chk("rst_ic_req_ready", bus.to_ic_rd_req_ready, 1'b0);
      clear_inputs();
      tick();
      rst = 1'b1;
      tick();

      // I-cache alone, 8-beat burst
      bus.from_mem_rd_req_ready = 1'b1;
      bus.from_ic_rd_req_valid  = 1'b1;
      bus.from_ic_rd_req_addr   = 32'h0000_1040;
      #1;
      chk("idle_no_req", bus.to_mem_rd_req_valid, 1'b0);
      tick();
      serve(1'b0, 32'h0000_1040, 8, 32'hA0);

      // three back-to-back ties
      for (int r = 0; r < 3; r++) begin
         bus.from_ic_rd_req_valid = 1'b1;
         bus.from_ic_rd_req_addr  = 32'h100;
         bus.from_dc_rd_req_valid = 1'b1;
         bus.from_dc_rd_req_addr  = 32'h200;
         tick();
`ifdef MEM_RD_ARB_RR_EN
         exp_dc = (r % 2 == 0);
`else
         exp_dc = 1'b1;
`endif
         serve(exp_dc, exp_dc ? 32'h200 : 32'h100, 2, 32'h10 * (r + 1));
      end
      // D-cache withdraws, pending I-cache request is served
      bus.from_dc_rd_req_valid = 1'b0;
      bus.from_ic_rd_req_valid = 1'b1;
      bus.from_ic_rd_req_addr  = 32'h100;
      tick();
      serve(1'b0, 32'h100, 1, 32'h77);

      // memory request stall, then response back-pressure
      bus.from_mem_rd_req_ready = 1'b0;
      bus.from_dc_rd_req_valid  = 1'b1;
      bus.from_dc_rd_req_addr   = 32'h3000;
      tick();
      for (int c = 0; c < 5; c++) begin
         chk("stall_req_valid", bus.to_mem_rd_req_valid, 1'b1);
         chk("stall_req_addr", bus.to_mem_rd_req_addr, 32'h3000);
         chk("stall_dc_ready", bus.to_dc_rd_req_ready, 1'b0);
         tick();
      end
      bus.from_mem_rd_req_ready = 1'b1;
      #1;
      chk("stall_release_ready", bus.to_dc_rd_req_ready, 1'b1);
      tick();
      bus.from_dc_rd_req_valid = 1'b0;
      beat = 0;
      for (int c = 0; c < 20 && beat < 6; c++) begin
         bus.from_mem_rd_rsp_valid = 1'b1;
         bus.from_mem_rd_rsp_data  = 32'hD0 + 32'(beat);
         bus.from_mem_rd_rsp_last  = (beat == 5);
         bus.from_dc_rd_rsp_ready  = !(c >= 2 && c <= 4);
         #1;
         chk("bp_valid", bus.to_dc_rd_rsp_valid, 1'b1);
         chk("bp_data", bus.to_dc_rd_rsp_data, 32'hD0 + 32'(beat));
         chk("bp_mem_ready", bus.to_mem_rd_rsp_ready, !(c >= 2 && c <= 4));
         if (!(c >= 2 && c <= 4)) beat++;
         tick();
      end
      bus.from_mem_rd_rsp_valid = 1'b0;
      bus.from_mem_rd_rsp_last  = 1'b0;
      bus.from_dc_rd_rsp_ready  = 1'b0;
      #1;
      chk("bp_idle_after", 3'(dut.state), 3'b001);

      // asynchronous reset at beat 4 of 8
      bus.from_ic_rd_req_valid = 1'b1;
      bus.from_ic_rd_req_addr  = 32'h5000;
      tick();
      chk("rr_req_addr", bus.to_mem_rd_req_addr, 32'h5000);
      tick();
      bus.from_ic_rd_req_valid = 1'b0;
      bus.from_ic_rd_rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.from_mem_rd_rsp_valid = 1'b1;
         bus.from_mem_rd_rsp_data  = 32'h50 + 32'(i);
         #1;
         chk("pre_rst_valid", bus.to_ic_rd_rsp_valid, 1'b1);
         if (i < 3) tick();
      end
      #1;
      rst = 1'b0;
      #1;
      chk("arst_rsp_valid", bus.to_ic_rd_rsp_valid, 1'b0);
      chk("arst_rsp_data", bus.to_ic_rd_rsp_data, 32'h0);
      chk("arst_mem_ready", bus.to_mem_rd_rsp_ready, 1'b0);
      chk("arst_state", 3'(dut.state), 3'b001);
      clear_inputs();
      tick(); tick();
      rst = 1'b1;
      tick();
      bus.from_mem_rd_req_ready = 1'b1;
      bus.from_ic_rd_req_valid  = 1'b1;
      bus.from_ic_rd_req_addr   = 32'h6000;
      tick();
      serve(1'b0, 32'h6000, 2, 32'h60);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mem_rd_arbiter.md
# mem_rd_arbiter

- Shares the single memory read channel between the I-cache and the D-cache miss paths.
- Grants one requester at a time and forwards its 32-byte-aligned read request to memory.
- Holds the grant for the whole burst, routing every response beat back to the granted cache, and releases only after the `last` beat is accepted.
- Sits between the two cache `to_mem_rd_*`/`from_mem_rd_*` ports and the memory/AXI bridge.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, request address width
- `DATA_WIDTH`, 32, response beat width

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low (asserted at 0)
- `from_ic_rd_req_valid`  in  1  I-cache read request valid
- `from_ic_rd_req_addr`  in  ADDR_WIDTH  I-cache request address
- `to_ic_rd_req_ready`  out  1  I-cache request accepted
- `to_ic_rd_rsp_valid`  out  1  beat valid to I-cache
- `to_ic_rd_rsp_data`  out  DATA_WIDTH  beat data to I-cache
- `to_ic_rd_rsp_last`  out  1  final beat to I-cache
- `from_ic_rd_rsp_ready`  in  1  I-cache accepts beat
- `from_dc_rd_req_valid`, `from_dc_rd_req_addr`, `to_dc_rd_req_ready`: D-cache request, same directions and widths as the I-cache ports
- `to_dc_rd_rsp_valid`, `to_dc_rd_rsp_data`, `to_dc_rd_rsp_last`, `from_dc_rd_rsp_ready`: D-cache response, same directions and widths as the I-cache ports
- `to_mem_rd_req_valid`  out  1  request to memory
- `to_mem_rd_req_addr`  out  ADDR_WIDTH  granted address, passed through unmodified
- `from_mem_rd_req_ready`  in  1  memory accepts request
- `from_mem_rd_rsp_valid`  in  1  memory beat valid
- `from_mem_rd_rsp_data`  in  DATA_WIDTH  memory beat data
- `from_mem_rd_rsp_last`  in  1  final beat of burst
- `to_mem_rd_rsp_ready`  out  1  granted cache accepts beat

## Operation
- State machine is one-hot: IDLE, REQ, RSP. Grant register `gnt` is 0 for I-cache, 1 for D-cache.
- **IDLE**
  - No valids: stay in IDLE.
  - Any valid: latch `gnt` per the arbitration policy (see Configuration), then go to REQ.
  - All outputs to requesters and memory are 0.
- **REQ**
  - `to_mem_rd_req_valid` = granted requester's valid.
  - `to_mem_rd_req_addr` = granted requester's address.
  - Granted `req_ready` = `from_mem_rd_req_ready`. Non-granted `req_ready` = 0.
  - Handshake (valid && ready): go to RSP.
  - Granted valid drops before the handshake (protocol violation): return to IDLE and issue nothing.
- **RSP**
  - Granted `rsp_valid`, `rsp_data` and `rsp_last` = memory beat fields.
  - `to_mem_rd_rsp_ready` = granted `rsp_ready`.
  - Non-granted `rsp_valid` = 0; its data is don't-care and is driven with the memory data.
  - A beat accepted with `last` = 1 returns to IDLE.
  - Beat count is unconstrained; only `last` ends the burst.
- While RSP is active, a request from the other cache waits: its `req_ready` stays 0 and its valid is held by the cache.
- `to_mem_rd_req_addr` = 0 whenever not in REQ.

## Timing
- Reset is asynchronous. While `rst` = 0:
  - State = IDLE, `gnt` = 0, round-robin pointer = 0 (next tie goes to D-cache).
  - Every output = 0.
- Reset asserted mid-REQ or mid-RSP aborts immediately. Any remaining beats are not acknowledged, and memory is reset by the same `rst`.
- Arbitration latency: a valid seen in IDLE at edge N yields `to_mem_rd_req_valid` = 1 in the cycle after edge N (one cycle).
- The REQ and RSP paths from inputs to outputs are combinational and add no latency.
- Back-to-back bursts: after the `last` beat, the arbiter spends at least one IDLE cycle before the next REQ.
- Both valids in the same IDLE cycle: the policy decides, and exactly one grant is issued.

## Configuration
- Macro `MEM_RD_ARB_RR_EN`.
- **Defined:** round-robin.
  - A 1-bit pointer records the last granted requester and is updated on the IDLE→REQ transition.
  - On a tie, the requester not granted last wins. A single requester always wins.
- **Undefined:** fixed priority. D-cache wins every tie, and the pointer logic is absent.

## Test plan
- I-cache alone requests addr 0x0000_1040; memory returns 8 beats 0xA0..0xA7 with `last` on beat 8 -> `to_mem_rd_req_addr` = 0x0000_1040 one cycle after valid; I-cache sees all 8 beats in order with `last` on the 8th; D-cache `rsp_valid` stays 0; state is IDLE the cycle after.
- Both caches request together (I 0x100, D 0x200), with `MEM_RD_ARB_RR_EN` defined and at reset -> D-cache is granted first and the I-cache follows; repeating the tie alternates the grant.
- Same tie with the macro undefined, repeated 3 times -> D-cache is granted all 3 times; I-cache is served only after D-cache valid drops.
- `from_mem_rd_req_ready` held 0 for 5 cycles while D-cache requests -> `to_mem_rd_req_valid` holds at 1 and the address is stable; `to_dc_rd_req_ready` is 0 until the ready cycle.
- Granted cache deasserts `rsp_ready` for 3 cycles mid-burst -> `to_mem_rd_rsp_ready` = 0 for those cycles; no beat is lost or duplicated.
- `rst` driven to 0 asynchronously at beat 4 of 8 -> all outputs go to 0 before the next edge; after release, a new I-cache request is served normally.
